// File: rtl/maple_in.sv
// Maple bus receiver: synchronizes pin1/pin5, decodes start/data/end patterns,
// and hands completed bytes to the read FIFO while tracking frame status.
module maple_in #(
    parameter int unsigned          START_PULSES = 4,
    parameter int unsigned          TIMEOUT_W    = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 16'd5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_p1,
    input  logic       in_p5,
    input  logic       arm,
    input  logic       abort,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [7:0] byte_count,
    output logic       status_start,
    output logic       status_end,
    output logic       status_error,
    output logic       status_ovf,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ENDP
    } state_t;

    localparam logic [3:0] START_CNT = 4'(START_PULSES);

    logic p1_meta_q, p1_sync_q, p1_hist_q;
    logic p5_meta_q, p5_sync_q, p5_hist_q;

    state_t               state_q, state_d;
    logic [3:0]           edge_cnt_q, edge_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic                 byte_done_q, byte_done_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic [7:0]           byte_count_q, byte_count_d;
    logic                 status_start_q, status_start_d;
    logic                 status_end_q, status_end_d;
    logic                 status_error_q, status_error_d;
    logic                 status_ovf_q, status_ovf_d;

    logic p1_fall, p1_rise, p5_fall, p5_rise;
    logic any_edge, both_edge, in_frame, timed_out, fail;

    // Lines idle high, so the synchronizers reset high to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_meta_q <= 1'b1;
            p1_sync_q <= 1'b1;
            p1_hist_q <= 1'b1;
            p5_meta_q <= 1'b1;
            p5_sync_q <= 1'b1;
            p5_hist_q <= 1'b1;
        end else begin
            p1_meta_q <= in_p1;
            p1_sync_q <= p1_meta_q;
            p1_hist_q <= p1_sync_q;
            p5_meta_q <= in_p5;
            p5_sync_q <= p5_meta_q;
            p5_hist_q <= p5_sync_q;
        end
    end

    assign p1_fall   = p1_hist_q & ~p1_sync_q;
    assign p1_rise   = ~p1_hist_q & p1_sync_q;
    assign p5_fall   = p5_hist_q & ~p5_sync_q;
    assign p5_rise   = ~p5_hist_q & p5_sync_q;
    assign any_edge  = p1_fall | p1_rise | p5_fall | p5_rise;
    assign both_edge = (p1_fall | p1_rise) & (p5_fall | p5_rise);
    assign in_frame  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_ENDP);
    assign timed_out = in_frame && !any_edge && (timer_q >= TIMEOUT - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_OFF;
            edge_cnt_q     <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            timer_q        <= '0;
            byte_done_q    <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            byte_count_q   <= '0;
            status_start_q <= 1'b0;
            status_end_q   <= 1'b0;
            status_error_q <= 1'b0;
            status_ovf_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            timer_q        <= timer_d;
            byte_done_q    <= byte_done_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            byte_count_q   <= byte_count_d;
            status_start_q <= status_start_d;
            status_end_q   <= status_end_d;
            status_error_q <= status_error_d;
            status_ovf_q   <= status_ovf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        timer_d        = '0;
        byte_done_d    = 1'b0;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        byte_count_d   = byte_count_q;
        status_start_d = status_start_q;
        status_end_d   = status_end_q;
        status_error_d = status_error_q;
        status_ovf_d   = status_ovf_q;
        fail           = 1'b0;

        if (in_frame) begin
            timer_d = any_edge ? '0 : timer_q + 1'b1;
        end

        if (abort) begin
            state_d = ST_OFF;
            timer_d = '0;
        end else begin
            // Completed byte leaves one cycle after its last bit was shifted in.
            if (byte_done_q) begin
                if (byte_count_q != 8'hFF) begin
                    byte_count_d = byte_count_q + 1'b1;
                end
                if (fifo_full) begin
                    status_ovf_d = 1'b1;
                end else begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                end
            end

            case (state_q)
                ST_OFF: begin
                    if (arm) begin
                        state_d        = ST_IDLE;
                        byte_count_d   = '0;
                        status_start_d = 1'b0;
                        status_end_d   = 1'b0;
                        status_error_d = 1'b0;
                        status_ovf_d   = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (p1_fall && p5_sync_q) begin
                        state_d    = ST_START;
                        edge_cnt_d = '0;
                    end
                end
                default: begin
                    if (both_edge || timed_out) begin
                        fail = 1'b1;
                    end else begin
                        case (state_q)
                            ST_START: begin
                                if (p5_fall && edge_cnt_q != 4'hF) begin
                                    edge_cnt_d = edge_cnt_q + 1'b1;
                                end
                                if (p1_rise) begin
                                    if (edge_cnt_q == START_CNT) begin
                                        status_start_d = 1'b1;
                                        state_d        = ST_DATA;
                                        bit_idx_d      = '0;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                            end
                            ST_DATA: begin
                                // Even bits are clocked by pin1, odd bits by pin5.
                                if (!bit_idx_q[0]) begin
                                    if (p1_fall) begin
                                        shift_d   = {shift_q[6:0], p5_sync_q};
                                        bit_idx_d = bit_idx_q + 1'b1;
                                    end else if (p5_fall) begin
                                        if (bit_idx_q == 3'd0) begin
                                            state_d    = ST_ENDP;
                                            edge_cnt_d = '0;
                                        end else begin
                                            fail = 1'b1;
                                        end
                                    end
                                end else begin
                                    if (p5_fall) begin
                                        shift_d   = {shift_q[6:0], p1_sync_q};
                                        bit_idx_d = bit_idx_q + 1'b1;
                                        if (bit_idx_q == 3'd7) begin
                                            byte_done_d = 1'b1;
                                        end
                                    end else if (p1_fall) begin
                                        fail = 1'b1;
                                    end
                                end
                            end
                            ST_ENDP: begin
                                if (p1_fall && !p5_sync_q && edge_cnt_q != 4'hF) begin
                                    edge_cnt_d = edge_cnt_q + 1'b1;
                                end
                                if (p5_rise) begin
                                    if (edge_cnt_q == 4'd2) begin
                                        status_end_d = 1'b1;
                                        state_d      = ST_OFF;
                                    end else begin
                                        fail = 1'b1;
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase

            if (fail) begin
                status_error_d = 1'b1;
                state_d        = ST_OFF;
                timer_d        = '0;
            end
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign byte_count   = byte_count_q;
    assign status_start = status_start_q;
    assign status_end   = status_end_q;
    assign status_error = status_error_q;
    assign status_ovf   = status_ovf_q;
    assign busy         = in_frame;

endmodule
